// File: rtl/seg_bcd_frame.sv
// seg_bcd_frame: frame feeder for an 8-digit 74HC595 seven-segment scanner.
//   Takes a binary value and a decimal-point mask over valid/ready. It converts
//   the value to BCD with an iterative double-dabble, then maps each digit to an
//   active-low common-anode segment byte. The new frame is committed only on the
//   scanner's frame_tick, so a scan never shows a half-updated display.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     value handshake
//   in_value[W-1:0]       unsigned binary value
//   in_dp[NDIG-1:0]       decimal-point enables (1 = lit), bit i -> digit i
//   frame_tick            scanner wrap pulse; commits a pending frame
//   dig_sel[2:0]          digit requested by scanner (0 = rightmost)
//   seg_byte[7:0]         combinational segment byte for dig_sel
//   busy                  conversion running or frame pending
//   ovf                   committed frame is an overflow (all dashes) frame
// Build option: define SEG_BCD_LZB_EN for leading-zero blanking.
module seg_bcd_frame #(
  parameter int unsigned NDIG = 8,
  parameter int unsigned W    = 27
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_value,
  input  logic [NDIG-1:0] in_dp,
  input  logic            frame_tick,
  input  logic [2:0]      dig_sel,
  output logic [7:0]      seg_byte,
  output logic            busy,
  output logic            ovf
);

  localparam int unsigned BW = 4 * (NDIG + 1);
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [NDIG-1:0]     dp_q, dp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [8*NDIG-1:0]   disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic [BW-2:0]       adj_c;
  logic [8*NDIG-1:0]   frame_c;
  logic                ovf_c;

  // Hex digit to active-low common-anode segment byte (bit7 = DP, off).
  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'h0: seg_lut = 8'hC0;  4'h1: seg_lut = 8'hF9;
      4'h2: seg_lut = 8'hA4;  4'h3: seg_lut = 8'hB0;
      4'h4: seg_lut = 8'h99;  4'h5: seg_lut = 8'h92;
      4'h6: seg_lut = 8'h82;  4'h7: seg_lut = 8'hF8;
      4'h8: seg_lut = 8'h80;  4'h9: seg_lut = 8'h90;
      4'hA: seg_lut = 8'h88;  4'hB: seg_lut = 8'h83;
      4'hC: seg_lut = 8'hC6;  4'hD: seg_lut = 8'hA1;
      4'hE: seg_lut = 8'h86;  default: seg_lut = 8'h8E;
    endcase
  endfunction

  // Double-dabble add-3 step. The top nibble's MSB is shifted out, so only
  // its low three bits are kept.
  always_comb begin : dabble_adjust
    logic [3:0] top;
    adj_c = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      adj_c[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                  : bcd_q[4*k +: 4];
    end
    top = bcd_q[BW-1 -: 4];
    adj_c[BW-2 -: 3] = (top >= 4'd5) ? 3'(top + 4'd3) : top[2:0];
  end

  // Segment image of the converted shadow frame, ready for commit.
  always_comb begin : frame_build
    logic [7:0] b;
`ifdef SEG_BCD_LZB_EN
    int unsigned msd;
`endif
    ovf_c   = (bcd_q[4*NDIG +: 4] != 4'd0);
    frame_c = '0;
    b       = 8'hFF;
`ifdef SEG_BCD_LZB_EN
    msd = 0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
`endif
    for (int unsigned i = 0; i < NDIG; i++) begin
      b = ovf_c ? 8'hBF : seg_lut(bcd_q[4*i +: 4]);
`ifdef SEG_BCD_LZB_EN
      // Digit 0 is never above msd, so it is always shown.
      if (!ovf_c && (i > msd)) b = 8'hFF;
`endif
      if (dp_q[i]) b[7] = 1'b0;
      frame_c[8*i +: 8] = b;
    end
  end

  // Next-state and datapath.
  always_comb begin : next_state
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    dp_d    = dp_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          bin_d   = in_value;
          dp_d    = in_dp;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {adj_c, bin_q[W-1]};
        bin_d = {bin_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = PEND;
      end
      PEND: begin
        if (frame_tick) begin
          disp_d  = frame_c;
          ovf_d   = ovf_c;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      dp_q       <= '0;
      cnt_q      <= '0;
      disp_q     <= '1;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      dp_q       <= dp_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Zero-latency digit read for the scanner; unused indices read blank.
  always_comb begin : seg_mux
    seg_byte = 8'hFF;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (dig_sel == 3'(i)) seg_byte = disp_q[8*i +: 8];
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_seg_bcd_frame.sv
// Testbench for seg_bcd_frame: scoreboard of expected frames pushed on accept,
// popped and compared after each commit.
module tb_seg_bcd_frame;

  localparam int unsigned NDIG = 8;
  localparam int unsigned W    = 27;

  typedef struct packed {
    logic        ovf;
    logic [63:0] segs;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_value = '0;
  logic [NDIG-1:0] in_dp = '0;
  logic            frame_tick = 1'b0;
  logic [2:0]      dig_sel = '0;
  logic [7:0]      seg_byte;
  logic            busy;
  logic            ovf;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  frame_t      exp_q[$];
  frame_t      cur;

  seg_bcd_frame #(.NDIG(NDIG), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_dp(in_dp), .frame_tick(frame_tick),
    .dig_sel(dig_sel), .seg_byte(seg_byte), .busy(busy), .ovf(ovf)
  );

  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] seg_hex(input int unsigned d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; default: return 8'h90;
    endcase
  endfunction

  // Reference model using plain decimal arithmetic.
  function automatic frame_t model(input logic [W-1:0] v, input logic [7:0] dp);
    frame_t          f;
    longint unsigned rem;
    int unsigned     d[9];
    int unsigned     msd;
    logic [7:0]      b;
    rem = longint'(v);
    for (int i = 0; i < 9; i++) begin
      d[i] = int'(rem % 10);
      rem  = rem / 10;
    end
    f.ovf = (d[8] != 0);
    msd = 0;
    for (int i = 0; i < 8; i++) if (d[i] != 0) msd = i;
    for (int i = 0; i < 8; i++) begin
      b = f.ovf ? 8'hBF : seg_hex(d[i]);
`ifdef SEG_BCD_LZB_EN
      if (!f.ovf && (i > msd)) b = 8'hFF;
`endif
      if (dp[i]) b[7] = 1'b0;
      f.segs[8*i +: 8] = b;
    end
    return f;
  endfunction

  task automatic read_display(output logic [63:0] s);
    for (int i = 0; i < 8; i++) begin
      dig_sel = 3'(i);
      #1;
      s[8*i +: 8] = seg_byte;
    end
    dig_sel = '0;
  endtask

  task automatic send(input logic [W-1:0] v, input logic [7:0] dp);
    int unsigned t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (!in_ready) begin
      $display("FAIL send_ready: in_ready=%b want 1 within 200 cycles", in_ready);
      return;
    end
    n_pass++;
    in_valid = 1'b1; in_value = v; in_dp = dp;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(model(v, dp));
  endtask

  task automatic do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] s;
    rst_n = 1'b0;
    @(negedge clk);
    read_display(s);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (s[8*i +: 8] !== 8'hFF) $display("FAIL reset_seg%0d: got %h want FF", i, s[8*i +: 8]);
      else n_pass++;
    end
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cur.ovf = 1'b0;
    cur.segs = '1;
  endtask

  task automatic test_basic();
    logic [63:0] s;
    frame_t e;
    send(W'(12345678), 8'h00);
    for (int c = 0; c < 40; c++) begin
      n_total++;
      if (in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL basic_wait c%0d: in_ready=%b busy=%b want 0/1", c, in_ready, busy);
      else n_pass++;
      @(negedge clk);
    end
    read_display(s);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (s[8*i +: 8] !== cur.segs[8*i +: 8])
        $display("FAIL basic_pre_seg%0d: got %h want %h", i, s[8*i +: 8], cur.segs[8*i +: 8]);
      else n_pass++;
    end
    do_tick();
    n_total++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_post_ready: in_ready=%b busy=%b want 1/0", in_ready, busy);
    else n_pass++;
    read_display(s);
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (s[8*i +: 8] !== e.segs[8*i +: 8])
        $display("FAIL basic_seg%0d: got %h want %h", i, s[8*i +: 8], e.segs[8*i +: 8]);
      else n_pass++;
    end
    n_total++;
    if (ovf !== e.ovf) $display("FAIL basic_ovf: got %b want %b", ovf, e.ovf); else n_pass++;
    cur = e;
  endtask

  task automatic test_dp();
    logic [63:0] s;
    frame_t e;
    logic [7:0] hi;
`ifdef SEG_BCD_LZB_EN
    hi = 8'hFF;
`else
    hi = 8'hC0;
`endif
    send(W'(5), 8'h01);
    repeat (W + 1) @(negedge clk);
    do_tick();
    read_display(s);
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (s[8*i +: 8] !== e.segs[8*i +: 8])
        $display("FAIL dp_seg%0d: got %h want %h", i, s[8*i +: 8], e.segs[8*i +: 8]);
      else n_pass++;
    end
    n_total++;
    if (s[7:0] !== 8'h12) $display("FAIL dp_digit0: got %h want 12", s[7:0]); else n_pass++;
    n_total++;
    if (s[63:56] !== hi) $display("FAIL dp_digit7: got %h want %h", s[63:56], hi); else n_pass++;
    cur = e;
  endtask

  task automatic test_overflow();
    logic [63:0] s;
    frame_t e;
    send(W'(100000000), 8'h00);
    repeat (W + 3) @(negedge clk);
    do_tick();
    read_display(s);
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (s[8*i +: 8] !== e.segs[8*i +: 8])
        $display("FAIL ovf_seg%0d: got %h want %h", i, s[8*i +: 8], e.segs[8*i +: 8]);
      else n_pass++;
    end
    n_total++;
    if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf); else n_pass++;
    n_total++;
    if (s[31:24] !== 8'hBF) $display("FAIL ovf_dash: got %h want BF", s[31:24]); else n_pass++;
    cur = e;
    send(W'(7), 8'h00);
    repeat (W + 1) @(negedge clk);
    do_tick();
    read_display(s);
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (s[8*i +: 8] !== e.segs[8*i +: 8])
        $display("FAIL ovf_clear_seg%0d: got %h want %h", i, s[8*i +: 8], e.segs[8*i +: 8]);
      else n_pass++;
    end
    n_total++;
    if (ovf !== 1'b0) $display("FAIL ovf_clear_flag: got %b want 0", ovf); else n_pass++;
    n_total++;
    if (s[7:0] !== 8'hF8) $display("FAIL ovf_clear_digit0: got %h want F8", s[7:0]); else n_pass++;
    cur = e;
  endtask

  task automatic test_back_to_back();
    logic [63:0] s;
    frame_t e;
    send(W'(24680135), 8'h84);
    // Second value held on the bus while the first converts.
    in_valid = 1'b1; in_value = W'(99); in_dp = 8'h00;
    for (int c = 0; c < int'(W) - 1; c++) begin
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL b2b_conv_ready c%0d: got %b want 0", c, in_ready);
      else n_pass++;
    end
    // Tick lands on the final CONV edge: must not commit.
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_total++;
    if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_late_tick: in_ready=%b busy=%b want 0/1", in_ready, busy);
    else n_pass++;
    read_display(s);
    n_total++;
    if (s !== cur.segs) $display("FAIL b2b_no_commit: got %h want %h", s, cur.segs); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL b2b_pend_ready: got %b want 0", in_ready); else n_pass++;
    do_tick();
    read_display(s);
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (s[8*i +: 8] !== e.segs[8*i +: 8])
        $display("FAIL b2b_a_seg%0d: got %h want %h", i, s[8*i +: 8], e.segs[8*i +: 8]);
      else n_pass++;
    end
    cur = e;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready_return: got %b want 1", in_ready); else n_pass++;
    // in_valid still high: accepted on this next edge.
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(model(W'(99), 8'h00));
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_b_accept: busy=%b want 1", busy); else n_pass++;
    repeat (W + 2) @(negedge clk);
    do_tick();
    read_display(s);
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (s[8*i +: 8] !== e.segs[8*i +: 8])
        $display("FAIL b2b_b_seg%0d: got %h want %h", i, s[8*i +: 8], e.segs[8*i +: 8]);
      else n_pass++;
    end
    cur = e;
  endtask

  task automatic test_reset_mid_conv();
    logic [63:0] s;
    send(W'(87654321), 8'hFF);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0)
      $display("FAIL rst_conv_flags: in_ready=%b busy=%b ovf=%b want 1/0/0", in_ready, busy, ovf);
    else n_pass++;
    read_display(s);
    n_total++;
    if (s !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rst_conv_blank: got %h want all FF", s);
    else n_pass++;
    exp_q.delete();
    cur.ovf = 1'b0;
    cur.segs = '1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) do_tick();
    repeat (W + 3) @(negedge clk);
    do_tick();
    read_display(s);
    n_total++;
    if (s !== cur.segs) $display("FAIL rst_conv_no_commit: got %h want %h", s, cur.segs);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_conv_idle: in_ready=%b busy=%b want 1/0", in_ready, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dp();
    test_overflow();
    test_back_to_back();
    test_reset_mid_conv();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
